ff_strobe_seq: RTL and testbench

Sequencer that drives the asynchronous preset/clear inputs of dual D flip-flop parts (74S74 style: active-low set, active-low reset per section). It accepts a request with a per-channel mode, produces glitch-free, registered, fixed-width active-low strobes, and never lets set and reset be low together on one channel. It sits between control logic and the flip-flop part models, for example in the machine-clear and power-on init paths.

---
 rtl/ff_strobe_pkg.sv | 19 +
 rtl/ff_strobe_timer.sv | 28 ++
 rtl/ff_strobe_seq.sv | 131 +++++++++++++
 tb/tb_ff_strobe_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_strobe_pkg.sv
// Shared types and constants for the 74S74 preset/clear strobe sequencer.
`timescale 1ns/1ps
package ff_strobe_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StSettle,
        StAckw
    } state_e;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_CLR  = 2'b01;
    localparam logic [1:0] MODE_SET  = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/ff_strobe_timer.sv
// 8-bit loadable down-counter with zero flag; holds at zero instead of wrapping.
`timescale 1ns/1ps
module ff_strobe_timer
    import ff_strobe_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ff_strobe_seq.sv
// Sequencer producing fixed-width, registered active-low preset/clear strobes
// for dual D flip-flop parts, with a four-phase REQ/ACK handshake.
`timescale 1ns/1ps
module ff_strobe_seq
    import ff_strobe_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned PULSE_W  = 4,
    parameter int unsigned SETTLE_W = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ,
    input  logic [2*NCH-1:0] MODE,
    output logic [NCH-1:0]   S_N,
    output logic [NCH-1:0]   R_N,
    output logic             BUSY,
    output logic             ACK,
    output logic             ERR
);

    localparam logic [TIMER_W-1:0] PULSE_LD  = TIMER_W'(PULSE_W - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LD = (SETTLE_W == 0) ? '0 : TIMER_W'(SETTLE_W - 1);

    state_e             state_q;
    logic [2*NCH-1:0]   mode_q;
    logic [NCH-1:0]     set_req;
    logic [NCH-1:0]     clr_req;
    logic [NCH-1:0]     bad_q;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;
    logic [TIMER_W-1:0] tmr_val;

    // Launch decode uses the live MODE so strobes fall on the accepting edge;
    // the error flags come from the latched copy.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign set_req[i] = (MODE[2*i +: 2] == MODE_SET);
        assign clr_req[i] = (MODE[2*i +: 2] == MODE_CLR);
        assign bad_q[i]   = (mode_q[2*i +: 2] == MODE_BAD);
    end

    ff_strobe_timer u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            StAssert: begin
                if (tmr_zero) begin
                    if (SETTLE_W != 0) begin
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LD;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StSettle: tmr_dec = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            mode_q  <= '0;
            S_N     <= '1;
            R_N     <= '1;
            BUSY    <= 1'b0;
            ACK     <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (REQ) begin
                        state_q <= StAssert;
                        mode_q  <= MODE;
                        S_N     <= ~set_req;
                        R_N     <= ~clr_req;
                        BUSY    <= 1'b1;
                    end
                end
                StAssert: begin
                    if (tmr_zero) begin
                        S_N <= '1;
                        R_N <= '1;
                        if (SETTLE_W == 0) begin
                            state_q <= StAckw;
                            ACK     <= 1'b1;
                            ERR     <= |bad_q;
                        end else begin
                            state_q <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    if (tmr_zero) begin
                        state_q <= StAckw;
                        ACK     <= 1'b1;
                        ERR     <= |bad_q;
                    end
                end
                StAckw: begin
                    if (!REQ) begin
                        state_q <= StIdle;
                        BUSY    <= 1'b0;
                        ACK     <= 1'b0;
                        ERR     <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_strobe_seq.sv
// Bench for ff_strobe_seq: one instance at PULSE_W=4/SETTLE_W=2, one at PULSE_W=1/SETTLE_W=0.
`timescale 1ns/1ps
module tb_ff_strobe_seq;

    localparam int PW_A = 4;
    localparam int SW_A = 2;
    localparam int PW_B = 1;
    localparam int SW_B = 0;
    localparam int NTBL = 12;

    typedef struct packed {
        logic [1:0] s_n;
        logic [1:0] r_n;
        logic       busy;
        logic       ack;
        logic       err;
    } out_t;

    typedef struct {
        int         dut;
        logic       req;
        logic [3:0] mode;
        out_t       exp;
    } vec_t;

    typedef struct {
        bit         busy;
        int         cnt;
        logic [3:0] mode;
    } model_t;

    typedef struct {
        int    dut;
        out_t  exp;
        string name;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, req_a, req_b;
    logic [3:0] mode_a, mode_b;
    logic [1:0] s_n_a, r_n_a, s_n_b, r_n_b;
    logic       busy_a, ack_a, err_a, busy_b, ack_b, err_b;

    int     n_vec;
    int     n_err;
    sb_t    sb_q[$];
    model_t ma, mb;
    vec_t   tbl[NTBL];

    always #5 clk = ~clk;

    ff_strobe_seq #(.NCH(2), .PULSE_W(PW_A), .SETTLE_W(SW_A)) dut_a (
        .CLK(clk), .RESET(rst_a), .REQ(req_a), .MODE(mode_a),
        .S_N(s_n_a), .R_N(r_n_a), .BUSY(busy_a), .ACK(ack_a), .ERR(err_a)
    );

    ff_strobe_seq #(.NCH(2), .PULSE_W(PW_B), .SETTLE_W(SW_B)) dut_b (
        .CLK(clk), .RESET(rst_b), .REQ(req_b), .MODE(mode_b),
        .S_N(s_n_b), .R_N(r_n_b), .BUSY(busy_b), .ACK(ack_b), .ERR(err_b)
    );

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input int dut, input logic req, input logic [3:0] mode,
                                input logic [1:0] s, input logic [1:0] r,
                                input logic b, input logic a, input logic e);
        vec_t v;
        v.dut  = dut;
        v.req  = req;
        v.mode = mode;
        v.exp  = out_t'({s, r, b, a, e});
        return v;
    endfunction

    // Reference: cycles counted from the accepting edge; strobes while cnt < pw,
    // acknowledge once cnt >= pw + sw, leave on the first low REQ after that.
    function automatic void predict(input model_t m, input logic req, input logic [3:0] mode,
                                    input int pw, input int sw,
                                    output model_t mn, output out_t e);
        logic [1:0] sn, rn, cm;
        logic       bad;
        mn = m;
        if (!m.busy) begin
            if (req) begin
                mn.busy = 1'b1;
                mn.cnt  = 0;
                mn.mode = mode;
            end
        end else if (m.cnt >= pw + sw && !req) begin
            mn.busy = 1'b0;
        end else begin
            mn.cnt = m.cnt + 1;
        end
        sn  = 2'b11;
        rn  = 2'b11;
        bad = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            cm = mn.mode[2*ch +: 2];
            if (mn.busy && mn.cnt < pw) begin
                if (cm == 2'b10) sn[ch] = 1'b0;
                if (cm == 2'b01) rn[ch] = 1'b0;
            end
            if (cm == 2'b11) bad = 1'b1;
        end
        e.s_n  = sn;
        e.r_n  = rn;
        e.busy = mn.busy;
        e.ack  = mn.busy && (mn.cnt >= pw + sw);
        e.err  = e.ack && bad;
    endfunction

    task automatic check_pop();
        sb_t        s;
        out_t       got;
        logic [1:0] sn, rn;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
            return;
        end
        s   = sb_q.pop_front();
        sn  = (s.dut == 0) ? s_n_a : s_n_b;
        rn  = (s.dut == 0) ? r_n_a : r_n_b;
        got = (s.dut == 0) ? out_t'({s_n_a, r_n_a, busy_a, ack_a, err_a})
                           : out_t'({s_n_b, r_n_b, busy_b, ack_b, err_b});
        check(s.name, 32'(got), 32'(s.exp));
        for (int ch = 0; ch < 2; ch++)
            check({s.name, "_set_clr_exclusive"}, 32'(sn[ch] | rn[ch]), 32'd1);
    endtask

    // Drive one cycle; expectation comes from the model unless a fixed one is given.
    task automatic drive(input int dut, input logic req, input logic [3:0] mode,
                         input bit fixed, input out_t fixed_exp, input string name);
        out_t   e;
        model_t n;
        sb_t    s;
        if (dut == 0) begin
            req_a  = req;
            mode_a = mode;
            predict(ma, req, mode, PW_A, SW_A, n, e);
            ma = n;
        end else begin
            req_b  = req;
            mode_b = mode;
            predict(mb, req, mode, PW_B, SW_B, n, e);
            mb = n;
        end
        if (fixed) e = fixed_exp;
        s.dut  = dut;
        s.exp  = e;
        s.name = name;
        sb_q.push_back(s);
        @(posedge clk);
        @(negedge clk);
        check_pop();
    endtask

    task automatic pulse_seq(input int dut, input logic [3:0] mode, input int hold,
                             input int tail, input string name);
        for (int i = 0; i < hold; i++) drive(dut, 1'b1, mode, 1'b0, '0, name);
        for (int i = 0; i < tail; i++) drive(dut, 1'b0, 4'h0, 1'b0, '0, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish required finish before 2000000");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        mode_a = 4'h0;
        mode_b = 4'h0;
        ma.busy = 1'b0;
        ma.cnt  = 0;
        ma.mode = 4'h0;
        mb = ma;

        // Basic sequence at 4/2, MODE changes after acceptance must be ignored.
        tbl[0]  = mk(0, 1'b1, 4'b1001, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mk(0, 1'b0, 4'b0110, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(0, 1'b0, 4'b0110, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(0, 1'b0, 4'b0000, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(0, 1'b0, 4'b0000, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(0, 1'b0, 4'b0000, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(0, 1'b0, 4'b0000, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
        tbl[7]  = mk(0, 1'b0, 4'b0000, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(0, 1'b0, 4'b0000, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        // Single-cycle strobe then immediate ACK at 1/0.
        tbl[9]  = mk(1, 1'b1, 4'b1001, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1, 1'b0, 4'b0000, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
        tbl[11] = mk(1, 1'b0, 4'b0000, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);

        #1;
        check("reset_a", 32'(out_t'({s_n_a, r_n_a, busy_a, ack_a, err_a})), 32'h78);
        check("reset_b", 32'(out_t'({s_n_b, r_n_b, busy_b, ack_b, err_b})), 32'h78);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 5; i++) drive(0, 1'b0, 4'h0, 1'b0, '0, "idle_a");
        for (int i = 0; i < 3; i++) drive(1, 1'b0, 4'h0, 1'b0, '0, "idle_b");

        for (int i = 0; i < NTBL; i++)
            drive(tbl[i].dut, tbl[i].req, tbl[i].mode, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));

        pulse_seq(0, 4'b0101, 20, 3, "held_req");
        pulse_seq(0, 4'b1101, 1, 9, "illegal_ch1");
        pulse_seq(0, 4'b1100, 2, 8, "illegal_none");
        pulse_seq(0, 4'b1010, 8, 2, "ack_on_entry_held");

        // Reset in the middle of ASSERT, between clock edges.
        drive(0, 1'b1, 4'b1001, 1'b0, '0, "mid_rst_pre");
        drive(0, 1'b0, 4'b1001, 1'b0, '0, "mid_rst_pre");
        drive(0, 1'b0, 4'b1001, 1'b0, '0, "mid_rst_pre");
        #2 rst_a = 1'b1;
        #1;
        check("mid_rst_strobes_async", 32'({s_n_a, r_n_a}), 32'hF);
        check("mid_rst_busy_async", 32'(busy_a), 32'd0);
        check("mid_rst_ack_async", 32'(ack_a), 32'd0);
        ma.busy = 1'b0;
        ma.cnt  = 0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_held", 32'(out_t'({s_n_a, r_n_a, busy_a, ack_a, err_a})), 32'h78);
        rst_a = 1'b0;
        pulse_seq(0, 4'b0000, 0, 2, "post_rst_idle");
        pulse_seq(0, 4'b0110, 1, 9, "post_rst_seq");

        pulse_seq(1, 4'b0111, 1, 3, "b_bad_ch0");
        pulse_seq(1, 4'b0101, 5, 2, "b_held");

        for (int i = 0; i < 600; i++)
            drive(0, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, '0, "rand_a");
        for (int i = 0; i < 10000; i++)
            drive(1, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, '0, "rand_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
